// File: rtl/alu_driver.sv
// Initiator for the ALU operand/opcode port: accepts a command, pulses ENA,
// waits LAT cycles, captures RGZ and returns it over a valid/ready handshake.
module alu_driver #(
    parameter int DW  = 8,
    parameter int OW  = 4,
    parameter int KW  = 2,
    parameter int LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CMD_VLD,
    output logic          CMD_RDY,
    input  logic [OW-1:0] CMD_OPT,
    input  logic [DW-1:0] CMD_A,
    input  logic [DW-1:0] CMD_B,
    input  logic [KW-1:0] CMD_KEY,
    input  logic          CMD_CHK,
    input  logic [DW-1:0] CMD_EXP,
    output logic          ENA,
    output logic [OW-1:0] OPT,
    output logic [DW-1:0] RGA,
    output logic [DW-1:0] RGB,
    output logic [KW-1:0] KEY,
    input  logic [DW-1:0] RGZ,
    output logic          RES_VLD,
    input  logic          RES_RDY,
    output logic [DW-1:0] RES_Z,
    output logic          RES_ERR,
    output logic [15:0]   OPS_CNT,
    output logic [7:0]    ERR_CNT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [OW-1:0] r_opt;
    logic [DW-1:0] r_rga;
    logic [DW-1:0] r_rgb;
    logic [KW-1:0] r_key;
    logic          r_chk;
    logic [DW-1:0] r_exp;
    logic [DW-1:0] r_res_z;
    logic          r_res_err;
    logic          r_res_vld;
    logic [15:0]   r_ops;
    logic [7:0]    r_errc;

    logic w_cmd_rdy;
    logic w_accept;

    // In HOLD the slot frees up on the same edge the result is taken
    assign w_cmd_rdy = (r_state == S_IDLE) || ((r_state == S_HOLD) && RES_RDY);
    assign w_accept  = CMD_VLD && w_cmd_rdy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_opt     <= '0;
            r_rga     <= '0;
            r_rgb     <= '0;
            r_key     <= '0;
            r_chk     <= 1'b0;
            r_exp     <= '0;
            r_res_z   <= '0;
            r_res_err <= 1'b0;
            r_res_vld <= 1'b0;
            r_ops     <= 16'd0;
            r_errc    <= 8'd0;
        end else begin
            if (w_accept) begin
                r_opt <= CMD_OPT;
                r_rga <= CMD_A;
                r_rgb <= CMD_B;
                r_key <= CMD_KEY;
                r_chk <= CMD_CHK;
                r_exp <= CMD_EXP;
            end
            case (r_state)
                S_IDLE: begin
                    if (CMD_VLD) r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_cnt   <= CNT_INIT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_res_z   <= RGZ;
                        r_res_err <= r_chk && (RGZ != r_exp);
                        r_res_vld <= 1'b1;
                        r_state   <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (RES_RDY) begin
                        r_ops     <= r_ops + 16'd1;
                        if (r_res_err) r_errc <= sat_inc8(r_errc);
                        r_res_vld <= 1'b0;
                        r_res_err <= 1'b0;
                        r_state   <= CMD_VLD ? S_ISSUE : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CMD_RDY = w_cmd_rdy;
    assign ENA     = (r_state == S_ISSUE);
    assign OPT     = r_opt;
    assign RGA     = r_rga;
    assign RGB     = r_rgb;
    assign KEY     = r_key;
    assign RES_VLD = r_res_vld;
    assign RES_Z   = r_res_z;
    assign RES_ERR = r_res_err;
    assign OPS_CNT = r_ops;
    assign ERR_CNT = r_errc;

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: two instances (LAT=1 and LAT=4), each with a simple
// registered ALU model, checked against a transaction-level reference.
module tb_alu_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cmd_opt = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0, cmd_exp = '0;
    logic [1:0] cmd_key = '0;
    logic       cmd_chk = 1'b0;

    logic vld1 = 1'b0, rrdy1 = 1'b0, rdy1, ena1, rvld1, rerr1;
    logic [3:0] opt1; logic [7:0] rga1, rgb1, rz1, rgz1 = '0, errc1;
    logic [1:0] key1; logic [15:0] ops1;

    logic vld4 = 1'b0, rrdy4 = 1'b0, rdy4, ena4, rvld4, rerr4;
    logic [3:0] opt4; logic [7:0] rga4, rgb4, rz4, rgz4 = '0, errc4;
    logic [1:0] key4; logic [15:0] ops4;

    int total = 0, bad = 0;
    int m_ops = 0, m_err = 0;
    logic [7:0] e_z;
    logic       e_e;

    always #5 clk = ~clk;

    alu_driver #(.DW(8), .OW(4), .KW(2), .LAT(1)) u_dut1 (
        .CLK(clk), .RST(rst), .CMD_VLD(vld1), .CMD_RDY(rdy1), .CMD_OPT(cmd_opt),
        .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_KEY(cmd_key), .CMD_CHK(cmd_chk),
        .CMD_EXP(cmd_exp), .ENA(ena1), .OPT(opt1), .RGA(rga1), .RGB(rgb1),
        .KEY(key1), .RGZ(rgz1), .RES_VLD(rvld1), .RES_RDY(rrdy1), .RES_Z(rz1),
        .RES_ERR(rerr1), .OPS_CNT(ops1), .ERR_CNT(errc1)
    );

    alu_driver #(.DW(8), .OW(4), .KW(2), .LAT(4)) u_dut4 (
        .CLK(clk), .RST(rst), .CMD_VLD(vld4), .CMD_RDY(rdy4), .CMD_OPT(cmd_opt),
        .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_KEY(cmd_key), .CMD_CHK(cmd_chk),
        .CMD_EXP(cmd_exp), .ENA(ena4), .OPT(opt4), .RGA(rga4), .RGB(rgb4),
        .KEY(key4), .RGZ(rgz4), .RES_VLD(rvld4), .RES_RDY(rrdy4), .RES_Z(rz4),
        .RES_ERR(rerr4), .OPS_CNT(ops4), .ERR_CNT(errc4)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [1:0] key);
        logic [7:0] r;
        case (op[1:0])
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a & b;
            default: r = a ^ b;
        endcase
        return (key == 2'd3) ? ~r : r;
    endfunction

    // ALU stand-ins: result available the cycle after ENA and held afterwards
    always @(posedge clk) begin
        if (ena1) rgz1 <= alu_f(opt1, rga1, rgb1, key1);
        if (ena4) rgz4 <= alu_f(opt4, rga4, rgb4, key4);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] key, input logic chk, input logic [7:0] ex);
        cmd_opt = op; cmd_a = a; cmd_b = b; cmd_key = key; cmd_chk = chk; cmd_exp = ex;
    endtask

    task automatic latch_expect();
        e_z = alu_f(cmd_opt, cmd_a, cmd_b, cmd_key);
        e_e = cmd_chk && (e_z != cmd_exp);
    endtask

    task automatic send();
        total++;
        if (rdy1 !== 1'b1) begin bad++; $display("FAIL send_cmd_rdy: got %b want 1", rdy1); end
        vld1 = 1'b1;
        latch_expect();
        tick();
        vld1 = 1'b0;
    endtask

    task automatic wait_res();
        int lat = 0;
        int enas = 0;
        while (rvld1 !== 1'b1 && lat < 20) begin
            if (ena1 === 1'b1) enas++;
            tick();
            lat++;
        end
        total++;
        if (lat != 2) begin bad++; $display("FAIL latency: got %0d want 2", lat); end
        total++;
        if (enas != 1) begin bad++; $display("FAIL ena_pulses: got %0d want 1", enas); end
        total++;
        if (rz1 !== e_z) begin bad++; $display("FAIL res_z: got %h want %h", rz1, e_z); end
        total++;
        if (rerr1 !== e_e) begin bad++; $display("FAIL res_err: got %b want %b", rerr1, e_e); end
    endtask

    task automatic ack();
        rrdy1 = 1'b1;
        tick();
        rrdy1 = 1'b0;
        m_ops++;
        if (e_e) m_err++;
        total++;
        if (ops1 !== 16'(m_ops)) begin bad++; $display("FAIL ops_cnt: got %0d want %0d", ops1, 16'(m_ops)); end
        total++;
        if (errc1 !== ((m_err > 255) ? 8'hFF : 8'(m_err))) begin
            bad++; $display("FAIL err_cnt: got %0d want %0d", errc1, (m_err > 255) ? 255 : m_err);
        end
        total++;
        if (rvld1 !== 1'b0 || rerr1 !== 1'b0) begin
            bad++; $display("FAIL res_clear: got vld=%b err=%b want 0 0", rvld1, rerr1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({ena1, rvld1, rerr1, opt1, rga1, rgb1, key1, rz1, ops1, errc1} !== '0) begin
            bad++; $display("FAIL reset_dut1: got ena=%b vld=%b ops=%0d errc=%0d want zeros", ena1, rvld1, ops1, errc1);
        end
        total++;
        if ({ena4, rvld4, rerr4, opt4, rga4, rgb4, key4, rz4, ops4, errc4} !== '0) begin
            bad++; $display("FAIL reset_dut4: got ena=%b vld=%b ops=%0d want zeros", ena4, rvld4, ops4);
        end
        total++;
        if (rdy1 !== 1'b1 || rdy4 !== 1'b1) begin
            bad++; $display("FAIL reset_cmd_rdy: got %b %b want 1 1", rdy1, rdy4);
        end
        m_ops = 0; m_err = 0;
    endtask

    task automatic test_single();
        set_cmd(4'd0, 8'h07, 8'h00, 2'd1, 1'b1, 8'h07);
        send();
        wait_res();
        ack();
        total++;
        if (opt1 !== 4'd0 || rga1 !== 8'h07 || rgb1 !== 8'h00 || key1 !== 2'd1) begin
            bad++; $display("FAIL idle_bus_hold: got opt=%h a=%h b=%h key=%h want 0 07 00 1", opt1, rga1, rgb1, key1);
        end
    endtask

    task automatic test_mismatch();
        set_cmd(4'd0, 8'h05, 8'h00, 2'd1, 1'b1, 8'h06);
        send(); wait_res(); ack();
        set_cmd(4'd0, 8'h05, 8'h00, 2'd1, 1'b0, 8'h06);
        send(); wait_res(); ack();
    endtask

    task automatic test_backpressure();
        logic [7:0] z0;
        set_cmd(4'd1, 8'h33, 8'h11, 2'd2, 1'b1, 8'h22);
        send(); wait_res();
        z0 = rz1;
        vld1 = 1'b1;
        set_cmd(4'd2, 8'hF0, 8'h3C, 2'd0, 1'b1, 8'h30);
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (rz1 !== z0 || rvld1 !== 1'b1 || rdy1 !== 1'b0 || ena1 !== 1'b0) begin
                bad++; $display("FAIL bp_hold: got z=%h vld=%b rdy=%b ena=%b want %h 1 0 0", rz1, rvld1, rdy1, ena1, z0);
            end
        end
        ack();
        vld1 = 1'b0;
        total++;
        if (ena1 !== 1'b1) begin bad++; $display("FAIL bp_release_ena: got %b want 1", ena1); end
        latch_expect();
        wait_res(); ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] alist [4] = '{8'h07, 8'h05, 8'h06, 8'h02};
        logic [7:0] qz [$];
        logic       qe [$];
        logic [7:0] ez, gz;
        logic       ee;
        int issued = 0, done = 0, last_ena = -1;
        set_cmd(4'd0, alist[0], 8'h00, 2'd0, 1'b1, alist[0]);
        vld1 = 1'b1; rrdy1 = 1'b1;
        for (int cyc = 0; cyc < 200 && done < 20; cyc++) begin
            if (ena1 === 1'b1) begin
                if (last_ena >= 0) begin
                    total++;
                    if (cyc - last_ena != 3) begin bad++; $display("FAIL b2b_ena_period: got %0d want 3", cyc - last_ena); end
                end
                last_ena = cyc;
            end
            if (rvld1 === 1'b1) begin
                gz = qz.pop_front(); ee = qe.pop_front();
                total++;
                if (rz1 !== gz || rerr1 !== ee) begin
                    bad++; $display("FAIL b2b_result: got z=%h err=%b want %h %b", rz1, rerr1, gz, ee);
                end
                done++; m_ops++;
                if (ee) m_err++;
            end
            if (rdy1 === 1'b1 && vld1 === 1'b1) begin
                ez = alu_f(cmd_opt, cmd_a, cmd_b, cmd_key);
                qz.push_back(ez);
                qe.push_back(cmd_chk && (ez != cmd_exp));
                issued++;
                tick();
                if (issued < 20) begin
                    ez = (issued < 4) ? alist[issued] : 8'($urandom);
                    set_cmd(4'($urandom), ez, 8'($urandom), 2'($urandom), 1'($urandom),
                            ($urandom_range(0, 1) == 0) ? ez : 8'($urandom));
                end else begin
                    vld1 = 1'b0;
                end
            end else begin
                tick();
            end
        end
        vld1 = 1'b0; rrdy1 = 1'b0;
        total++;
        if (done != 20) begin bad++; $display("FAIL b2b_done: got %0d want 20", done); end
        total++;
        if (ops1 !== 16'(m_ops)) begin bad++; $display("FAIL b2b_ops_cnt: got %0d want %0d", ops1, m_ops); end
    endtask

    task automatic test_random();
        logic [7:0] a, z0;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            set_cmd(4'($urandom), a, 8'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) cmd_exp = alu_f(cmd_opt, cmd_a, cmd_b, cmd_key);
            send(); wait_res();
            z0 = rz1;
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                tick();
                total++;
                if (rz1 !== z0 || rvld1 !== 1'b1) begin
                    bad++; $display("FAIL rand_hold: got z=%h vld=%b want %h 1", rz1, rvld1, z0);
                end
            end
            ack();
        end
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 262; i++) begin
            set_cmd(4'd0, 8'($urandom), 8'h00, 2'd0, 1'b1, 8'h00);
            cmd_exp = cmd_a + 8'd1;
            send(); wait_res(); ack();
        end
        total++;
        if (errc1 !== 8'hFF) begin bad++; $display("FAIL err_cnt_sat: got %h want ff", errc1); end
    endtask

    task automatic test_reset_mid_wait();
        int lat = 0;
        logic [7:0] ez;
        set_cmd(4'd3, 8'h5A, 8'h0F, 2'd3, 1'b1, 8'h00);
        ez = alu_f(cmd_opt, cmd_a, cmd_b, cmd_key);
        vld4 = 1'b1; tick(); vld4 = 1'b0;
        while (rvld4 !== 1'b1 && lat < 20) begin tick(); lat++; end
        total++;
        if (lat != 5 || rz4 !== ez || rerr4 !== 1'b1) begin
            bad++; $display("FAIL lat4_result: got lat=%0d z=%h err=%b want 5 %h 1", lat, rz4, rerr4, ez);
        end
        rrdy4 = 1'b1; tick(); rrdy4 = 1'b0;
        total++;
        if (ops4 !== 16'd1) begin bad++; $display("FAIL lat4_ops: got %0d want 1", ops4); end
        set_cmd(4'd1, 8'h99, 8'h11, 2'd2, 1'b0, 8'h00);
        vld4 = 1'b1; tick(); vld4 = 1'b0;
        tick();
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if (ena4 !== 1'b0 || rvld4 !== 1'b0 || ops4 !== 16'd0 || rdy4 !== 1'b1 ||
            {opt4, rga4, rgb4, key4} !== '0) begin
            bad++; $display("FAIL mid_wait_reset: got ena=%b vld=%b ops=%0d rdy=%b a=%h want 0 0 0 1 00",
                            ena4, rvld4, ops4, rdy4, rga4);
        end
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (rvld4 !== 1'b0 || ena4 !== 1'b0) begin
            bad++; $display("FAIL mid_wait_ghost: got vld=%b ena=%b want 0 0", rvld4, ena4);
        end
        m_ops = 0; m_err = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_mismatch();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_err_saturation();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
